// File: rtl/tl_pkg.sv
// Shared intersection-controller types: phase ids, scheduler states and green saturation.
package tl_pkg;

  typedef enum logic [1:0] {
    PH_MAIN = 2'd0,
    PH_LEFT = 2'd1,
    PH_SEC  = 2'd2,
    PH_PED  = 2'd3
  } phase_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_PREEMPT,
    ST_CLEAR
  } sched_state_t;

  localparam int GREEN_MAX = 31;

  function automatic logic [4:0] sat_green(input logic [5:0] sum);
    return (sum > 6'(GREEN_MAX)) ? 5'(GREEN_MAX) : sum[4:0];
  endfunction

endpackage

// File: rtl/phase_scheduler_rr_arbiter.sv
// 4-way round-robin arbiter; a non-empty force mask overrides rotation (lowest forced id wins).
module rr_arbiter
  import tl_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  input  logic [3:0] force_mask,
  output logic [3:0] grant,
  output logic [1:0] grant_id
);

  logic [1:0] idx;
  logic       found;

  // With no request at all the rest phase (MAIN) is granted.
  always_comb begin
    grant_id = PH_MAIN;
    idx      = '0;
    found    = 1'b0;
    if (|force_mask) begin
      for (int i = 3; i >= 0; i--) begin
        if (force_mask[i]) grant_id = 2'(i);
      end
    end else begin
      for (int k = 1; k <= 4; k++) begin
        idx = ptr + 2'(k);
        if (!found && req[idx]) begin
          grant_id = idx;
          found    = 1'b1;
        end
      end
    end
    grant = 4'b0001 << grant_id;
  end

endmodule

// File: rtl/phase_scheduler.sv
// Intersection phase scheduler: round-robin grants, emergency preemption, all-red clearance.
// Define STARVE_GUARD_EN to build the skip counters and starvation override.
module phase_scheduler
  import tl_pkg::*;
#(
  parameter int BASE_MAIN    = 20,
  parameter int BASE_LEFT    = 6,
  parameter int BASE_SEC     = 10,
  parameter int BASE_PED     = 10,
  parameter int STARVE_LIMIT = 4,
  parameter int CLEAR_CYC    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] main_num,
  input  logic [2:0] left_num,
  input  logic [2:0] sec_num,
  input  logic       p_req,
  input  logic       m_emergency,
  input  logic       s_emergency,
  output logic       phase_valid,
  output logic [1:0] phase_id,
  output logic [4:0] phase_green,
  input  logic       phase_ready,
  input  logic       phase_done,
  output logic       preempt,
  output logic       preempt_dir
);

  localparam int CLR_W = (CLEAR_CYC > 1) ? $clog2(CLEAR_CYC) : 1;

  sched_state_t     state;
  logic [1:0]       ptr;
  logic             ped_pending;
  logic [3:0]       granted_q;
  logic [CLR_W-1:0] clear_cnt;
  logic [3:0]       demand;
  logic [3:0]       force_mask;
  logic [3:0]       grant;
  logic [1:0]       grant_id;
  logic [5:0]       base;
  logic [2:0]       num;
  logic [4:0]       green_next;
  logic             emergency;
  logic             accept;

  assign emergency   = m_emergency | s_emergency;
  assign accept      = (state == ST_ISSUE) && phase_ready && !emergency;
  assign demand      = {ped_pending, |sec_num, |left_num, |main_num};
  assign phase_valid = (state == ST_ISSUE);
  assign preempt     = (state == ST_PREEMPT);

  rr_arbiter u_arb (
    .req        (demand),
    .ptr        (ptr),
    .force_mask (force_mask),
    .grant      (grant),
    .grant_id   (grant_id)
  );

`ifdef STARVE_GUARD_EN
  logic [2:0] skip_cnt [4];

  // Skips only move on an accepted command; a preempted command leaves them untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) skip_cnt[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < 4; i++) begin
        if (granted_q[i])     skip_cnt[i] <= '0;
        else if (demand[i])   skip_cnt[i] <= (skip_cnt[i] == 3'd7) ? 3'd7 : skip_cnt[i] + 3'd1;
        else                  skip_cnt[i] <= '0;
      end
    end
  end

  always_comb begin
    force_mask = '0;
    for (int i = 0; i < 4; i++) force_mask[i] = (32'(skip_cnt[i]) >= STARVE_LIMIT);
  end
`else
  logic [31:0] unused_starve_limit;
  assign unused_starve_limit = STARVE_LIMIT;
  assign force_mask          = '0;
`endif

  always_comb begin
    base = 6'(BASE_MAIN);
    num  = main_num;
    case (grant_id)
      PH_LEFT: begin base = 6'(BASE_LEFT); num = left_num; end
      PH_SEC:  begin base = 6'(BASE_SEC);  num = sec_num;  end
      PH_PED:  begin base = 6'(BASE_PED);  num = '0;       end
      default: begin base = 6'(BASE_MAIN); num = main_num; end
    endcase
    green_next = sat_green(base + {2'b00, num, 1'b0});
  end

  // Emergencies override every state but IDLE; the pending command is simply dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      ptr         <= 2'd3;
      ped_pending <= 1'b0;
      granted_q   <= '0;
      clear_cnt   <= '0;
      phase_id    <= '0;
      phase_green <= '0;
      preempt_dir <= 1'b0;
    end else begin
      ped_pending <= p_req || (ped_pending && !(accept && granted_q[3]));
      if (emergency && state != ST_IDLE) begin
        state       <= ST_PREEMPT;
        preempt_dir <= !m_emergency;
      end else begin
        case (state)
          ST_IDLE: state <= ST_SELECT;
          ST_SELECT: begin
            phase_id    <= grant_id;
            phase_green <= green_next;
            granted_q   <= grant;
            state       <= ST_ISSUE;
          end
          ST_ISSUE: begin
            if (phase_ready) begin
              ptr   <= phase_id;
              state <= ST_WAIT_DONE;
            end
          end
          ST_WAIT_DONE: if (phase_done) state <= ST_SELECT;
          ST_PREEMPT: begin
            clear_cnt <= '0;
            state     <= ST_CLEAR;
          end
          ST_CLEAR: begin
            if (clear_cnt == CLR_W'(CLEAR_CYC - 1)) state <= ST_SELECT;
            else                                    clear_cnt <= clear_cnt + 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_phase_scheduler.sv
// Self-checking bench for phase_scheduler: directed steps plus randomized phases against a
// transaction-level model of the grant rules.
module tb_phase_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] main_num, left_num, sec_num;
  logic       p_req, m_emergency, s_emergency, phase_ready, phase_done;
  logic       phase_valid, preempt, preempt_dir;
  logic [1:0] phase_id;
  logic [4:0] phase_green;

  int vectors     = 0;
  int miscompares = 0;

  localparam int BASE_T [4] = '{20, 6, 10, 10};
`ifdef STARVE_GUARD_EN
  localparam int STARVE_LIMIT = 4;
`endif

  int m_ptr;
  int m_skip [4];
  bit m_ped;
  int cur_id;
  int cur_green;

  always #5 clk = ~clk;

  phase_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .main_num    (main_num),
    .left_num    (left_num),
    .sec_num     (sec_num),
    .p_req       (p_req),
    .m_emergency (m_emergency),
    .s_emergency (s_emergency),
    .phase_valid (phase_valid),
    .phase_id    (phase_id),
    .phase_green (phase_green),
    .phase_ready (phase_ready),
    .phase_done  (phase_done),
    .preempt     (preempt),
    .preempt_dir (preempt_dir)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: who has demand, who wins, and how long they get.
  function automatic bit has_demand(input int id);
    case (id)
      0:       return main_num != 0;
      1:       return left_num != 0;
      2:       return sec_num != 0;
      default: return m_ped;
    endcase
  endfunction

  function automatic int predict_id();
`ifdef STARVE_GUARD_EN
    for (int i = 0; i < 4; i++) if (m_skip[i] >= STARVE_LIMIT) return i;
`endif
    for (int k = 1; k <= 4; k++) if (has_demand((m_ptr + k) % 4)) return (m_ptr + k) % 4;
    return 0;
  endfunction

  function automatic int predict_green(input int id);
    int n;
    case (id)
      0:       n = int'(main_num);
      1:       n = int'(left_num);
      2:       n = int'(sec_num);
      default: n = 0;
    endcase
    return (BASE_T[id] + 2 * n > 31) ? 31 : BASE_T[id] + 2 * n;
  endfunction

  task automatic model_reset();
    m_ptr = 3;
    m_ped = 1'b0;
    for (int i = 0; i < 4; i++) m_skip[i] = 0;
  endtask

  task automatic model_accept(input int id);
    for (int i = 0; i < 4; i++) begin
      if (i == id)            m_skip[i] = 0;
      else if (has_demand(i)) m_skip[i] = (m_skip[i] >= 7) ? 7 : m_skip[i] + 1;
      else                    m_skip[i] = 0;
    end
    m_ptr = id;
    if (id == 3) m_ped = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [2:0] m, input logic [2:0] l, input logic [2:0] s);
    main_num = m;
    left_num = l;
    sec_num  = s;
  endtask

  task automatic pulse_ped();
    p_req = 1'b1;
    step();
    p_req = 1'b0;
    m_ped = 1'b1;
  endtask

  task automatic end_phase();
    phase_done = 1'b1;
    step();
    phase_done = 1'b0;
  endtask

  task automatic expect_cmd(input string tag);
    int got;
    got = 0;
    for (int i = 0; i < 12 && got == 0; i++) begin
      if (phase_valid === 1'b1) got = 1;
      else step();
    end
    check_output({tag, "_valid_seen"}, got, 1);
    cur_id    = predict_id();
    cur_green = predict_green(cur_id);
    check_output({tag, "_id"}, phase_id, cur_id);
    check_output({tag, "_green"}, phase_green, cur_green);
  endtask

  task automatic accept_cmd(input int delay);
    for (int i = 0; i < delay; i++) begin
      step();
      check_output("hold_valid", phase_valid, 1);
      check_output("hold_id", phase_id, cur_id);
      check_output("hold_green", phase_green, cur_green);
    end
    phase_ready = 1'b1;
    step();
    phase_ready = 1'b0;
    check_output("valid_drop", phase_valid, 0);
    model_accept(cur_id);
  endtask

  task automatic emerg_step(input logic m, input logic s);
    m_emergency = m;
    s_emergency = s;
    step();
    check_output("preempt_on", preempt, 1);
    check_output("preempt_valid_low", phase_valid, 0);
    check_output("preempt_dir", preempt_dir, m ? 0 : 1);
  endtask

  // Release to reissue spans CLEAR_CYC+2 edges; the abandoned command comes back unchanged.
  task automatic release_and_reissue();
    m_emergency = 1'b0;
    s_emergency = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_output("clear_preempt_low", preempt, 0);
      check_output("clear_valid_low", phase_valid, 0);
    end
    step();
    check_output("reissue_valid", phase_valid, 1);
    check_output("reissue_id", phase_id, cur_id);
    check_output("reissue_green", phase_green, cur_green);
  endtask

  function automatic logic [2:0] rnd_cnt();
    return ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
  endfunction

  initial begin
    rst         = 1'b0;
    p_req       = 1'b0;
    m_emergency = 1'b0;
    s_emergency = 1'b0;
    phase_ready = 1'b0;
    phase_done  = 1'b0;
    apply_stimulus(3'd0, 3'd0, 3'd0);
    model_reset();
    step();
    step();
    check_output("reset_valid", phase_valid, 0);
    check_output("reset_preempt", preempt, 0);
    check_output("reset_dir", preempt_dir, 0);
    check_output("reset_id", phase_id, 0);
    check_output("reset_green", phase_green, 0);

    rst         = 1'b1;
    phase_ready = 1'b1;
    step();
    check_output("first_select_valid", phase_valid, 0);
    step();
    check_output("first_valid", phase_valid, 1);
    check_output("first_id", phase_id, 0);
    check_output("first_green", phase_green, 20);
    step();
    check_output("first_accept_drop", phase_valid, 0);
    phase_ready = 1'b0;
    model_accept(0);

    apply_stimulus(3'd3, 3'd2, 3'd4);
    end_phase();
    expect_cmd("rr1");
    check_output("rr1_left", phase_green, 10);
    accept_cmd(0);
    end_phase();
    expect_cmd("rr2");
    check_output("rr2_sec", phase_green, 18);
    accept_cmd(1);
    end_phase();
    expect_cmd("rr3");
    check_output("rr3_main", phase_green, 26);
    accept_cmd(2);
    end_phase();
    expect_cmd("rr4");
    check_output("rr4_left_id", phase_id, 1);
    accept_cmd(0);
    end_phase();
    expect_cmd("rr5");
    check_output("rr5_sec_id", phase_id, 2);
    accept_cmd(0);

    pulse_ped();
    end_phase();
    expect_cmd("ped");
    check_output("ped_id", phase_id, 3);
    check_output("ped_green", phase_green, 10);
    accept_cmd(0);
    apply_stimulus(3'd0, 3'd0, 3'd0);
    end_phase();
    expect_cmd("ped_cleared");
    check_output("ped_cleared_id", phase_id, 0);
    accept_cmd(0);

    apply_stimulus(3'd7, 3'd0, 3'd0);
    end_phase();
    expect_cmd("sat");
    check_output("sat_green31", phase_green, 31);
    accept_cmd(0);

    apply_stimulus(3'd0, 3'd5, 3'd0);
    end_phase();
    expect_cmd("pre");
    check_output("pre_left_green", phase_green, 16);
    emerg_step(1'b0, 1'b1);
    emerg_step(1'b1, 1'b1);
    release_and_reissue();
    accept_cmd(0);

    apply_stimulus(3'd1, 3'd0, 3'd1);
    pulse_ped();
    rst = 1'b0;
    #1;
    check_output("async_rst_valid", phase_valid, 0);
    check_output("async_rst_preempt", preempt, 0);
    check_output("async_rst_id", phase_id, 0);
    check_output("async_rst_green", phase_green, 0);
    model_reset();
    step();
    rst = 1'b1;
    step();
    check_output("rerst_select_valid", phase_valid, 0);
    step();
    check_output("rerst_valid", phase_valid, 1);
    check_output("rerst_ptr_main", phase_id, 0);
    check_output("rerst_green", phase_green, 22);
    cur_id    = 0;
    cur_green = 22;
    accept_cmd(0);

    for (int n = 0; n < 40; n++) begin
      apply_stimulus(rnd_cnt(), rnd_cnt(), rnd_cnt());
      if ($urandom_range(0, 3) == 0) pulse_ped();
      end_phase();
      expect_cmd("rand");
      if ($urandom_range(0, 4) == 0) begin
        int hold;
        logic em;
        hold = $urandom_range(1, 3);
        for (int h = 0; h < hold; h++) begin
          em = 1'($urandom_range(0, 1));
          emerg_step(em, em ? 1'($urandom_range(0, 1)) : 1'b1);
        end
        release_and_reissue();
      end
      accept_cmd($urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
